// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - shared constants, BCD time type and digit helpers for time_keeper
package time_keeper_pkg;

    localparam int CLKS_PER_SEC_DEF = 256;
    localparam int SECS_PER_MIN     = 60;

    localparam logic [3:0] MAX_MS_HR       = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN      = 4'd5;
    localparam logic [3:0] MAX_DIGIT       = 4'd9;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

    function automatic logic load_valid(input bcd_time_t t);
        logic ok;
        ok = (t.ms_hr <= MAX_MS_HR) && (t.ls_hr <= MAX_DIGIT) &&
             (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_DIGIT);
        if (t.ms_hr == MAX_MS_HR && t.ls_hr > MAX_LS_HR_AT_20) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple a one-minute increment through the BCD digits, wrapping 23:59 to 00:00.
    function automatic bcd_time_t advance_minute(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.ls_min != MAX_DIGIT) begin
            n.ls_min = t.ls_min + 4'd1;
        end else begin
            n.ls_min = 4'd0;
            if (t.ms_min != MAX_MS_MIN) begin
                n.ms_min = t.ms_min + 4'd1;
            end else begin
                n.ms_min = 4'd0;
                if (t.ms_hr == MAX_MS_HR && t.ls_hr == MAX_LS_HR_AT_20) begin
                    n.ms_hr = 4'd0;
                    n.ls_hr = 4'd0;
                end else if (t.ls_hr == MAX_DIGIT) begin
                    n.ls_hr = 4'd0;
                    n.ms_hr = t.ms_hr + 4'd1;
                end else begin
                    n.ls_hr = t.ls_hr + 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - controller-facing signal bundle of time_keeper
interface time_keeper_if;

    logic       reset_count;
    logic       load_new_c;
    logic       fast_watch;
    logic [3:0] new_current_time_ms_hr;
    logic [3:0] new_current_time_ls_hr;
    logic [3:0] new_current_time_ms_min;
    logic [3:0] new_current_time_ls_min;

    logic       one_second;
    logic       one_minute;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic       load_err;

    modport master (
        output reset_count, load_new_c, fast_watch,
               new_current_time_ms_hr, new_current_time_ls_hr,
               new_current_time_ms_min, new_current_time_ls_min,
        input  one_second, one_minute, load_err,
               current_time_ms_hr, current_time_ls_hr,
               current_time_ms_min, current_time_ls_min
    );

    modport slave (
        input  reset_count, load_new_c, fast_watch,
               new_current_time_ms_hr, new_current_time_ls_hr,
               new_current_time_ms_min, new_current_time_ls_min,
        output one_second, one_minute, load_err,
               current_time_ms_hr, current_time_ls_hr,
               current_time_ms_min, current_time_ls_min
    );

endinterface

// File: rtl/sec_gen.sv
// rtl/sec_gen.sv - prescaler and seconds counter producing one_second / one_minute strobes
module sec_gen
    import time_keeper_pkg::*;
#(
    parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_reset_count,
    output logic o_one_second,
    output logic o_one_minute
);

    localparam int          CW      = $clog2(CLKS_PER_SEC);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SEC - 1);
    localparam logic [5:0]  SEC_MAX = 6'(SECS_PER_MIN - 1);

    logic [CW-1:0] r_clk_cnt;
    logic [5:0]    r_sec_cnt;
    logic          w_one_second;

    // Strobes are pure decodes of the counters so they stay glitch-free Moore outputs.
    assign w_one_second = (r_clk_cnt == CNT_MAX);
    assign o_one_second = w_one_second;
    assign o_one_minute = w_one_second && (r_sec_cnt == SEC_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_reset_count) begin
            r_clk_cnt <= '0;
            r_sec_cnt <= '0;
        end else begin
            r_clk_cnt <= w_one_second ? '0 : r_clk_cnt + 1'b1;
            if (w_one_second) begin
                r_sec_cnt <= (r_sec_cnt == SEC_MAX) ? 6'd0 : r_sec_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - HH:MM BCD clock with validated load, fast mode and seconds generator
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEF
) (
    input  logic          clock,
    input  logic          reset,
    time_keeper_if.slave  tk
);

    logic      w_one_second;
    logic      w_one_minute;
    logic      w_min_tick;
    logic      w_load_ok;
    bcd_time_t w_new_time;
    bcd_time_t r_time;
    logic      r_load_err;

    sec_gen #(
        .CLKS_PER_SEC (CLKS_PER_SEC)
    ) u_sec_gen (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_reset_count (tk.reset_count),
        .o_one_second  (w_one_second),
        .o_one_minute  (w_one_minute)
    );

    assign w_new_time = '{ms_hr:  tk.new_current_time_ms_hr,
                          ls_hr:  tk.new_current_time_ls_hr,
                          ms_min: tk.new_current_time_ms_min,
                          ls_min: tk.new_current_time_ls_min};
    assign w_load_ok  = load_valid(w_new_time);
    // A tick seen while the counters are being cleared belongs to the old time base; drop it.
    assign w_min_tick = (tk.fast_watch ? w_one_second : w_one_minute) && !tk.reset_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_time     <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (tk.load_new_c) begin
                if (w_load_ok) begin
                    r_time <= w_new_time;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_min_tick) begin
                r_time <= advance_minute(r_time);
            end
        end
    end

    assign tk.one_second          = w_one_second;
    assign tk.one_minute          = w_one_minute;
    assign tk.load_err            = r_load_err;
    assign tk.current_time_ms_hr  = r_time.ms_hr;
    assign tk.current_time_ls_hr  = r_time.ls_hr;
    assign tk.current_time_ms_min = r_time.ms_min;
    assign tk.current_time_ls_min = r_time.ls_min;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - scoreboard bench for time_keeper against a minutes-of-day reference model
module tb_time_keeper;

    localparam int C = 4;

    logic clock = 1'b0;
    logic reset;
    time_keeper_if tk_if ();

    time_keeper #(.CLKS_PER_SEC(C)) dut (
        .clock (clock),
        .reset (reset),
        .tk    (tk_if)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        os;
        logic        om;
        logic        err;
        logic [15:0] t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   n_om = 0;
    int   n_err = 0;
    bit   started = 0;

    int   m_cyc = 0;
    int   m_mins = 0;
    bit   m_err = 0;

    function automatic logic [15:0] to_bcd(input int mins);
        int h;
        int m;
        h = mins / 60;
        m = mins % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic bit valid_time(input int a, input int b, input int c, input int d);
        return (a <= 2) && (b <= 9) && (a * 10 + b <= 23) && (c <= 5) && (d <= 9);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            n_om  += int'(tk_if.one_minute === 1'b1);
            n_err += int'(tk_if.load_err === 1'b1);
        end
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("one_second", int'(tk_if.one_second), int'(mon_e.os));
            chk("one_minute", int'(tk_if.one_minute), int'(mon_e.om));
            chk("load_err",   int'(tk_if.load_err),   int'(mon_e.err));
            chk("time", int'({tk_if.current_time_ms_hr, tk_if.current_time_ls_hr,
                              tk_if.current_time_ms_min, tk_if.current_time_ls_min}),
                int'(mon_e.t));
        end
    end

    task automatic step(input bit rst, input bit rc, input bit ld, input bit fw,
                        input int a, input int b, input int c, input int d, input bit push);
        bit os;
        bit om;
        bit tick;
        reset                           = rst;
        tk_if.reset_count               = rc;
        tk_if.load_new_c                = ld;
        tk_if.fast_watch                = fw;
        tk_if.new_current_time_ms_hr    = 4'(a);
        tk_if.new_current_time_ls_hr    = 4'(b);
        tk_if.new_current_time_ms_min   = 4'(c);
        tk_if.new_current_time_ls_min   = 4'(d);
        os = (m_cyc % C) == C - 1;
        om = os && (((m_cyc / C) % 60) == 59);
        if (push) begin
            exp_q.push_back('{os: os, om: om, err: m_err, t: to_bcd(m_mins)});
        end
        if (rst) begin
            m_cyc = 0; m_mins = 0; m_err = 0;
        end else begin
            tick  = fw ? os : om;
            m_err = 0;
            if (ld) begin
                if (valid_time(a, b, c, d)) m_mins = (a * 10 + b) * 60 + c * 10 + d;
                else m_err = 1;
            end else if (tick && !rc) begin
                m_mins = (m_mins + 1) % 1440;
            end
            m_cyc = rc ? 0 : m_cyc + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input bit fw);
        for (int i = 0; i < n; i++) step(0, 0, 0, fw, 0, 0, 0, 0, 1);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        tk_if.reset_count = 1'b0;
        tk_if.load_new_c  = 1'b0;
        tk_if.fast_watch  = 1'b0;
        tk_if.new_current_time_ms_hr  = 4'd0;
        tk_if.new_current_time_ls_hr  = 4'd0;
        tk_if.new_current_time_ms_min = 4'd0;
        tk_if.new_current_time_ls_min = 4'd0;
        @(posedge clock);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        started = 1;
        step(1, 1, 1, 1, 1, 2, 3, 4, 1);

        base = n_om;
        idle(242, 0);
        chk("one_minute_count_240", n_om - base, 1);

        base = n_err;
        step(0, 0, 1, 1, 2, 3, 5, 9, 1);
        idle(8, 1);
        chk("load_err_count_2359", n_err - base, 0);

        base = n_err;
        step(0, 0, 1, 0, 2, 4, 0, 0, 1);
        idle(3, 0);
        step(0, 0, 1, 0, 1, 2, 6, 0, 1);
        idle(3, 0);
        chk("load_err_count_bad", n_err - base, 2);

        for (int k = 0; k < C && (m_cyc % C) != C - 1; k++) idle(1, 1);
        step(0, 1, 1, 1, 1, 0, 4, 5, 1);
        idle(10, 1);

        step(0, 1, 1, 0, 0, 5, 1, 7, 1);
        idle(120, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(20, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 10),
                 $urandom_range(0, 6), $urandom_range(0, 10), 1);
        end
        idle(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
